mc_ctrl_fsm: RTL

Multi-cycle control unit for the 32-bit RV32I Fibonacci core. Sequences fetch, decode, execute, memory and write-back over the shared datapath: register file, ALU, unified memory port and the immediate generator. Decodes the registered instruction word (IR) into `imm_sel` and datapath strobes, and handles memory-port wait states. Raises a sticky trap on illegal opcodes or memory timeout.

---
 rtl/mc_ctrl_pkg.sv | 59 +++++
 rtl/mc_main_dec.sv | 38 +++
 rtl/mc_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle RV32I control unit.
//   - state_t     : FSM state encoding
//   - iclass_t    : instruction class produced by the main decoder
//   - IMM_*       : immediate-format codes, shared with the immediate generator
//   - OPC_*       : RV32I major opcodes (instr[6:0])
//   - ALU_*, WB_*, CAUSE_* : alu_op, wb_sel and trap_cause encodings
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_OP,
        CLS_OPIMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_ILLEGAL
    } iclass_t;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_main_dec.sv
// mc_main_dec: purely combinational main decoder.
// Ports:
//   i_opcode  in  7  instr[6:0]
//   o_class   out 4  instruction class (iclass_t encoding)
//   o_imm_sel out 3  immediate format; R-type and illegal opcodes give IMM_I
//   o_illegal out 1  opcode is not an RV32I class handled by this core
module mc_main_dec
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [3:0] o_class,
    output logic [2:0] o_imm_sel,
    output logic       o_illegal
);

    iclass_t w_class;

    always_comb begin
        w_class   = CLS_ILLEGAL;
        o_imm_sel = IMM_I;
        case (i_opcode)
            OPC_OP:     w_class = CLS_OP;
            OPC_OPIMM:  w_class = CLS_OPIMM;
            OPC_LOAD:   w_class = CLS_LOAD;
            OPC_JALR:   w_class = CLS_JALR;
            OPC_STORE:  begin w_class = CLS_STORE;  o_imm_sel = IMM_S; end
            OPC_BRANCH: begin w_class = CLS_BRANCH; o_imm_sel = IMM_B; end
            OPC_LUI:    begin w_class = CLS_LUI;    o_imm_sel = IMM_U; end
            OPC_AUIPC:  begin w_class = CLS_AUIPC;  o_imm_sel = IMM_U; end
            OPC_JAL:    begin w_class = CLS_JAL;    o_imm_sel = IMM_J; end
            default:    ;
        endcase
    end

    assign o_class   = w_class;
    assign o_illegal = (w_class == CLS_ILLEGAL);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control unit for the RV32I Fibonacci core.
// Sequences FETCH/DECODE/EXEC/MEM/WB over the shared datapath and traps on
// illegal opcodes or memory-port timeout (sticky until rst).
// Ports:
//   clk, rst (async, active-high)
//   instr[31:0], branch_taken, mem_ready            inputs
//   mem_req, mem_we, addr_sel                        memory port control
//   ir_we, old_pc_we, pc_we, reg_we                  register write strobes
//   pc_src, alu_src_a, alu_src_b, alu_op[1:0]        datapath selects
//   wb_sel[1:0], imm_sel[2:0]                        write-back / immediate select
//   trap, trap_cause[1:0]                            sticky trap status
//   retired_cnt[31:0]                                retired-instruction count
// Parameter: TIMEOUT_CYC (>=2) wait cycles allowed before a timeout trap.
// Build option: define MC_CTRL_RETIRE_CNT_EN to build the retire counter;
// otherwise retired_cnt is tied to 0.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        old_pc_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        pc_src,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic [2:0]  imm_sel,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] retired_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYC);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic              r_trap;
    logic [1:0]        r_trap_cause;

    logic [3:0]        w_class_raw;
    iclass_t           w_class;
    logic              w_illegal;
    logic              w_retire;
    logic              w_unused_instr;

    mc_main_dec u_dec (
        .i_opcode  (instr[6:0]),
        .o_class   (w_class_raw),
        .o_imm_sel (imm_sel),
        .o_illegal (w_illegal)
    );

    assign w_class        = iclass_t'(w_class_raw);
    assign w_unused_instr = ^instr[31:7];

    // The final state of every instruction is the one that moves to FETCH.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            ST_EXEC: w_retire = (w_class == CLS_BRANCH) || (w_class == CLS_JAL) ||
                                (w_class == CLS_JALR);
            ST_MEM:  w_retire = mem_ready && (w_class == CLS_STORE);
            ST_WB:   w_retire = 1'b1;
            default: ;
        endcase
    end

    // r_wait counts cycles already spent waiting in the current access; a
    // cycle with no ready while r_wait == TIMEOUT_CYC-1 is the last allowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_wait       <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= CAUSE_NONE;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        r_state <= ST_DECODE;
                    end else if (r_wait == WAIT_LAST) begin
                        r_state      <= ST_TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= CAUSE_TIMEOUT;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (w_illegal) begin
                        r_state      <= ST_TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= CAUSE_ILLEGAL;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_wait <= '0;
                    case (w_class)
                        CLS_LOAD, CLS_STORE:          r_state <= ST_MEM;
                        CLS_BRANCH, CLS_JAL, CLS_JALR: r_state <= ST_FETCH;
                        default:                      r_state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        r_wait  <= '0;
                        r_state <= (w_class == CLS_LOAD) ? ST_WB : ST_FETCH;
                    end else if (r_wait == WAIT_LAST) begin
                        r_state      <= ST_TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= CAUSE_TIMEOUT;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ST_WB: begin
                    r_wait  <= '0;
                    r_state <= ST_FETCH;
                end
                ST_TRAP: r_state <= ST_TRAP;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // Strobes are decoded from state/opcode so that a same-cycle mem_ready
    // completes the access; everything is held low while rst is asserted.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        old_pc_we = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        pc_src    = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        wb_sel    = WB_ALU;
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we     = 1'b1;
                        old_pc_we = 1'b1;
                        pc_we     = 1'b1;
                    end
                end
                ST_DECODE: begin
                    // ALU is idle here: precompute old_pc + imm so a taken
                    // branch can load it from the ALU result in EXEC.
                    alu_src_a = 1'b1;
                    alu_src_b = 1'b1;
                end
                ST_EXEC: begin
                    case (w_class)
                        CLS_OP:    alu_op = ALU_FUNCT;
                        CLS_OPIMM: begin alu_op = ALU_FUNCT; alu_src_b = 1'b1; end
                        CLS_LOAD, CLS_STORE, CLS_LUI: alu_src_b = 1'b1;
                        CLS_AUIPC: begin alu_src_a = 1'b1; alu_src_b = 1'b1; end
                        CLS_JAL, CLS_JALR: begin
                            alu_src_a = (w_class == CLS_JAL);
                            alu_src_b = 1'b1;
                            reg_we    = 1'b1;
                            wb_sel    = WB_PC4;
                            pc_we     = 1'b1;
                            pc_src    = 1'b1;
                        end
                        CLS_BRANCH: begin
                            alu_op = ALU_CMP;
                            pc_we  = branch_taken;
                            pc_src = branch_taken;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (w_class == CLS_STORE);
                end
                ST_WB: begin
                    reg_we = 1'b1;
                    wb_sel = (w_class == CLS_LOAD) ? WB_MEM : WB_ALU;
                end
                default: ;
            endcase
        end
    end

    assign trap       = r_trap;
    assign trap_cause = r_trap_cause;

`ifdef MC_CTRL_RETIRE_CNT_EN
    logic [31:0] r_retired_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired_cnt <= '0;
        end else if (w_retire) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
        end
    end

    assign retired_cnt = r_retired_cnt;
`else
    logic w_unused_retire;
    assign w_unused_retire = w_retire;
    assign retired_cnt     = '0;
`endif

endmodule
